div_unit: RTL and testbench

- Multicycle 32-bit signed integer divider for DIV: the responder side of the start/done handshake the multicycle datapath uses for its long-latency arithmetic units.
- The control unit pulses div_start with operands held in A/B. The divider iterates one quotient bit per cycle, then pulses div_end.
- Results go to HI (remainder) and LO (quotient). A zero divisor raises div_zero so the control unit can take the exception path.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle signed/unsigned divider.
package div_pkg;

    // Default operand/result width; the divider runs one quotient bit per cycle.
    localparam int unsigned DIV_WIDTH = 32;

    // Width of the iteration counter for the default width.
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    // Divider control states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        ZERO = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    // The shifted remainder needs WIDTH+1 bits: with a divisor above 2^(WIDTH-1)
    // the remainder can itself exceed half range before the shift.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; keep the difference only when it does not underflow.
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {1'b0, dvs_i};
        q_o     = (shifted >= {1'b0, dvs_i});
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle integer divider answering the start/done handshake of the control
// unit. Quotient goes to lo_out, remainder to hi_out; a zero divisor finishes
// after one cycle with div_zero. Optional DIVU support: define DIV_UNIT_DIVU_EN
// to add the div_unsigned input.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             div_start,
`ifdef DIV_UNIT_DIVU_EN
    input  logic             div_unsigned,
`endif
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // dvd_q shifts the dividend out at the top and collects quotient bits at the
    // bottom, so after WIDTH steps it holds the unsigned quotient.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

`ifdef DIV_UNIT_DIVU_EN
    assign signed_op = ~div_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, apply signs in FIX.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    sign_q_d = signed_op & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    sign_r_d = signed_op & a_in[WIDTH-1];
                    // Magnitudes; the most negative value maps to itself, which
                    // is the correct unsigned magnitude.
                    dvd_d    = (signed_op && a_in[WIDTH-1]) ? -a_in : a_in;
                    dvs_d    = (signed_op && b_in[WIDTH-1]) ? -b_in : b_in;
                    rem_d    = '0;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    state_d  = (b_in == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                lo_d    = sign_q_q ? -dvd_q : dvd_q;
                hi_d    = sign_r_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the registered state.
    always_comb begin
        busy     = (state_q != IDLE);
        div_end  = (state_q == DONE) || (state_q == ZERO);
        div_zero = (state_q == ZERO);
        hi_out   = hi_q;
        lo_out   = lo_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares whenever div_end is seen.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        div_start;
`ifdef DIV_UNIT_DIVU_EN
    logic        div_unsigned;
`endif
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_end;
    logic        div_zero;
    logic        busy;

    int unsigned cyc;
    int          errors;
    int          checks;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .b_in      (b_in),
        .div_start (div_start),
`ifdef DIV_UNIT_DIVU_EN
        .div_unsigned (div_unsigned),
`endif
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_end   (div_end),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value seen at a negedge is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each completion against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && div_end) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_div_end: got div_end at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lo_out", lo_out, e.lo);
                chk("hi_out", hi_out, e.hi);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.z});
                chk("end_cycle", cyc, e.cyc);
            end
        end
        if (!reset && div_zero && !div_end) begin
            checks++;
            errors++;
            $display("FAIL zero_without_end: got div_zero=1 div_end=0 expected both");
        end
    end

    // Issue one request at the next negedge and record its expected result.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi, input bit uns);
        exp_t e;
        @(negedge clk);
        a_in      = a;
        b_in      = b;
        div_start = 1'b1;
`ifdef DIV_UNIT_DIVU_EN
        div_unsigned = uns;
`endif
        e.lo  = lo;
        e.hi  = hi;
        e.z   = (b == 32'd0);
        e.cyc = cyc + ((b == 32'd0) ? 1 : 34);
        exp_q.push_back(e);
        @(negedge clk);
        div_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int   busy_cnt;
        exp_t e;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        reset     = 1'b1;
        a_in      = '0;
        b_in      = '0;
        div_start = 1'b0;
`ifdef DIV_UNIT_DIVU_EN
        div_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_end", {31'd0, div_end}, 32'd0);
        chk("rst_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 100 / 7 with busy-length measurement (now at cycle 1 after return)
        do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        busy_cnt = busy ? 1 : 0;
        repeat (39) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("busy_cycles", busy_cnt, 32'd34);
        wait_idle();

        // Divide by zero keeps the previous result
        do_div(32'd5, 32'd0, 32'd14, 32'd2, 1'b0);
        wait_idle();
        do_div(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        wait_idle();
        do_div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
        wait_idle();
        do_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        wait_idle();

        // Re-pulse while busy is ignored
        do_div(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        a_in      = 32'd7;
        b_in      = 32'd3;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        wait_idle();

        // div_start held high: back-to-back with one IDLE cycle between
        @(negedge clk);
        a_in      = 32'd50;
        b_in      = 32'd5;
        div_start = 1'b1;
        e.lo = 32'd10; e.hi = 32'd0; e.z = 1'b0; e.cyc = cyc + 34;
        exp_q.push_back(e);
        e.lo = 32'd2; e.hi = 32'd1; e.z = 1'b0; e.cyc = cyc + 69;
        exp_q.push_back(e);
        @(negedge clk);
        a_in = 32'd9;
        b_in = 32'd4;
        repeat (35) @(negedge clk);
        div_start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation discards the result
        do_div(32'd200, 32'd3, 32'd66, 32'd2, 1'b0);
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_hi", hi_out, 32'd0);
        chk("ar_lo", lo_out, 32'd0);
        chk("ar_end", {31'd0, div_end}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        do_div(32'd77, 32'hFFFFFFFB, 32'hFFFFFFF1, 32'd2, 1'b0);
        wait_idle();

`ifdef DIV_UNIT_DIVU_EN
        do_div(32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b1);
        wait_idle();
        do_div(32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b0);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
